// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch unit: the fetch FSM state
//   encoding, the instruction word width, the sequential PC increment and the
//   default reset PC.
// ----------------------------------------------------------------------------
package fetch_pkg;

   // BOOT  : seeds the external PC register with the reset PC
   // FETCH : memory request outstanding for the current PC
   // VALID : instruction held for decode until it is accepted
   // DRAIN : memory request outstanding whose data will be thrown away
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   localparam int          INST_W           = 32;
   localparam int unsigned PC_INC           = 4;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage : fetch_pkg

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch controller. Drives an external program counter register
//   (pc_value / pc_next / pc_load), issues one instruction-memory request at a
//   time and hands each fetched word to decode over a valid/ready handshake.
//   Branch/jump redirects reload the PC and throw away any fetch in flight.
//
// Ports
//   clk, rst_n        : single clock, synchronous active-low reset
//   pc_value          : current value of the external PC register
//   pc_next, pc_load  : value / strobe to load the external PC register
//   imem_req/addr     : instruction memory request and its address
//   imem_ack/rdata    : memory acknowledge and the returned instruction word
//   inst_valid/ready  : decode-side handshake
//   inst, inst_pc     : the instruction offered to decode and its address
//   redirect_valid    : redirect request from branch resolution
//   redirect_target   : redirect address (low two bits are ignored)
//   state             : current FSM state, exported for observation
//
// Handshake rules
//   Memory: imem_req rises together with a new imem_addr; both hold until the
//   cycle imem_ack=1, which completes the request. A request is never
//   withdrawn, so a redirect only marks its data to be discarded.
//   Decode: inst_valid=1 offers inst/inst_pc; they are held unchanged until a
//   cycle with inst_ready=1 (transfer) or redirect_valid=1 (flush). A cycle
//   with both counts as a transfer followed by the redirect.
// ----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              BITS     = 64,
   parameter logic [BITS-1:0] RESET_PC = BITS'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BITS-1:0]   pc_value,
   output logic [BITS-1:0]   pc_next,
   output logic              pc_load,
   output logic              imem_req,
   output logic [BITS-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [BITS-1:0]   inst_pc,
   input  logic              redirect_valid,
   input  logic [BITS-1:0]   redirect_target,
   output fetch_state_t      state
);

   logic [BITS-1:0] redirect_pc;
   logic [BITS-1:0] inc_pc;
   logic [BITS-1:0] fetch_addr;
   logic            unused_ok;

   // Instructions are word aligned; the low target bits are dropped.
   assign redirect_pc = {redirect_target[BITS-1:2], 2'b00};
   assign unused_ok   = ^redirect_target[1:0];

   // Sequential successor of the address being fetched; wraps modulo 2^BITS.
   assign inc_pc = imem_addr + BITS'(PC_INC);

   // PC register control. Reset is folded into the BOOT term so the external
   // register is seeded on every reset edge, not only after release. A
   // redirect outranks the +4 increment; BOOT ignores redirects entirely.
   always_comb begin
      pc_load = 1'b0;
      pc_next = pc_value;
      if (!rst_n || state == ST_BOOT) begin
         pc_load = 1'b1;
         pc_next = RESET_PC;
      end else if (redirect_valid) begin
         pc_load = 1'b1;
         pc_next = redirect_pc;
      end else if (state == ST_FETCH && imem_ack) begin
         pc_load = 1'b1;
         pc_next = inc_pc;
      end
   end

   // Address for a new request. When the PC register is being loaded on this
   // same edge, pc_value is still the old value, so the load value is
   // forwarded; otherwise the register already holds the right address.
   assign fetch_addr = pc_load ? pc_next : pc_value;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_BOOT;
         imem_req   <= 1'b0;
         imem_addr  <= '0;
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               state     <= ST_FETCH;
               imem_req  <= 1'b1;
               imem_addr <= fetch_addr;
            end

            ST_FETCH: begin
               if (redirect_valid) begin
                  if (imem_ack) begin
                     // Stale data returned this cycle: drop it and start the
                     // request for the redirect target straight away.
                     imem_addr <= fetch_addr;
                  end else begin
                     // Request still open; it must finish before the new
                     // address may be presented.
                     state <= ST_DRAIN;
                  end
               end else if (imem_ack) begin
                  state      <= ST_VALID;
                  imem_req   <= 1'b0;
                  inst_valid <= 1'b1;
                  inst       <= imem_rdata;
                  inst_pc    <= imem_addr;
               end
            end

            ST_VALID: begin
               if (redirect_valid || inst_ready) begin
                  state      <= ST_FETCH;
                  inst_valid <= 1'b0;
                  imem_req   <= 1'b1;
                  imem_addr  <= fetch_addr;
               end
            end

            ST_DRAIN: begin
               // Further redirects only reload the PC (done combinationally);
               // the old request keeps its address until it is acknowledged.
               if (imem_ack) begin
                  state     <= ST_FETCH;
                  imem_addr <= fetch_addr;
               end
            end

            default: begin
               state      <= ST_BOOT;
               imem_req   <= 1'b0;
               inst_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : fetch_unit
